// File: rtl/tracking_iq_reader.sv
// tracking_iq_reader: drains packed I/Q words from a show-ahead FIFO and serialises them field-by-field.
// Define TRACKING_IQ_READER_HEADER_EN to prefix each word with a {2'b10, word_count} header beat.
module tracking_iq_reader #(
  parameter int WIDTH       = 108,
  parameter int FIELD_WIDTH = 18,
  parameter int NUM_FIELDS  = 6,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_q,
  output logic                   fifo_rdreq,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FIELD_WIDTH-1:0] out_data,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] word_count
);
`ifdef TRACKING_IQ_READER_HEADER_EN
  localparam int NB = NUM_FIELDS + 1;
  localparam int SW = WIDTH + FIELD_WIDTH;
`else
  localparam int NB = NUM_FIELDS;
  localparam int SW = WIDTH;
`endif
  localparam int IW = $clog2(NB);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          sr_q, sr_d, load;
  logic [IW-1:0]          idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                   accept, last;

  assign cnt_inc = cnt_q + 1'b1;

`ifdef TRACKING_IQ_READER_HEADER_EN
  // Header sits in the low field so it shifts out ahead of field 0.
  logic [FIELD_WIDTH-3:0] hdr_cnt;
  if (FIELD_WIDTH - 2 > COUNT_WIDTH) begin : g_pad
    assign hdr_cnt = {{(FIELD_WIDTH-2-COUNT_WIDTH){1'b0}}, cnt_inc};
  end else begin : g_trunc
    assign hdr_cnt = cnt_inc[FIELD_WIDTH-3:0];
  end
  assign load = {fifo_q, 2'b10, hdr_cnt};
`else
  assign load = fifo_q;
`endif

  assign out_valid  = state_q == SEND;
  assign busy       = state_q != IDLE;
  assign last       = idx_q == IW'(NB-1);
  assign accept     = out_valid && out_ready;
  assign out_data   = sr_q[FIELD_WIDTH-1:0];
  assign out_first  = out_valid && idx_q == '0;
  assign out_last   = out_valid && last;
  assign word_count = cnt_q;
  assign fifo_rdreq = !reset && !fifo_empty && (state_q == IDLE || (accept && last));

  always_comb begin
    state_d = fifo_rdreq ? SEND : (accept && last) ? IDLE : state_q;
    sr_d    = fifo_rdreq ? load : (accept && !last) ? sr_q >> FIELD_WIDTH : sr_q;
    idx_d   = fifo_rdreq ? '0 : (accept && !last) ? idx_q + 1'b1 : idx_q;
    cnt_d   = fifo_rdreq ? cnt_inc : cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
